// File: rtl/i2c_target_rx.sv
// I2C target with fixed 7-bit address; ~SYNC_STAGES+1 clk from bus edge to reaction, no local backpressure (initiator owns timing).
// Optional general-call write acceptance and gen_call output under `I2C_TARGET_GEN_CALL_EN.
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
`ifdef I2C_TARGET_GEN_CALL_EN
  output logic       gen_call,
`endif
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR_S, ACK_A, WR, ACK_W, RD, RACK, IGNORE
  } state_t;

  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_p, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] cnt, cnt_n;
  logic       full, full_n;
  logic [7:0] shift, shift_n;
  logic       sda_out_n, sda_oe_n, rx_valid_n, tx_req_n, busy_n;
  logic [7:0] rx_data_n;
  logic       addr_hit;
`ifdef I2C_TARGET_GEN_CALL_EN
  logic       gen_call_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & ~sda_s & sda_p;
  assign stop_det  = scl_s & scl_p & sda_s & ~sda_p;

  // Address 0 is never a plain match; it only qualifies as a general-call write.
`ifdef I2C_TARGET_GEN_CALL_EN
  assign addr_hit = ((shift[7:1] == ADDR) && (shift[7:1] != 7'd0)) || (shift == 8'h00);
`else
  assign addr_hit = (shift[7:1] == ADDR) && (shift[7:1] != 7'd0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd7;
      full     <= 1'b0;
      shift    <= 8'h00;
      sda_out  <= 1'b1;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
`ifdef I2C_TARGET_GEN_CALL_EN
      gen_call <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      full     <= full_n;
      shift    <= shift_n;
      sda_out  <= sda_out_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
`ifdef I2C_TARGET_GEN_CALL_EN
      gen_call <= gen_call_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    full_n     = full;
    shift_n    = shift;
    sda_out_n  = sda_out;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;
`ifdef I2C_TARGET_GEN_CALL_EN
    gen_call_n = gen_call;
`endif
    if (start_det || stop_det) begin
      state_n   = start_det ? ADDR_S : IDLE;
      cnt_n     = 3'd7;
      full_n    = 1'b0;
      sda_oe_n  = 1'b0;
      sda_out_n = 1'b1;
      busy_n    = 1'b0;
`ifdef I2C_TARGET_GEN_CALL_EN
      gen_call_n = 1'b0;
`endif
    end else begin
      case (state)
        ADDR_S: begin
          if (scl_rise && !full) begin
            shift_n = {shift[6:0], sda_s};
            if (cnt == 3'd0) full_n = 1'b1;
            else             cnt_n  = cnt - 3'd1;
          end else if (scl_fall && full) begin
            full_n = 1'b0;
            if (addr_hit) begin
              state_n   = ACK_A;
              sda_oe_n  = 1'b1;
              sda_out_n = 1'b0;
              busy_n    = 1'b1;
`ifdef I2C_TARGET_GEN_CALL_EN
              gen_call_n = (shift == 8'h00);
`endif
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ACK_A: begin
          if (scl_fall) begin
            cnt_n = 3'd7;
            if (shift[0]) begin
              // ACK level is held low until tx_data arrives on the tx_req cycle.
              tx_req_n = 1'b1;
              state_n  = RD;
            end else begin
              sda_oe_n  = 1'b0;
              sda_out_n = 1'b1;
              full_n    = 1'b0;
              state_n   = WR;
            end
          end
        end
        WR: begin
          if (scl_rise && !full) begin
            shift_n = {shift[6:0], sda_s};
            if (cnt == 3'd0) begin
              full_n     = 1'b1;
              rx_data_n  = {shift[6:0], sda_s};
              rx_valid_n = 1'b1;
            end else begin
              cnt_n = cnt - 3'd1;
            end
          end else if (scl_fall && full) begin
            full_n    = 1'b0;
            sda_oe_n  = 1'b1;
            sda_out_n = 1'b0;
            state_n   = ACK_W;
          end
        end
        ACK_W: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            sda_out_n = 1'b1;
            cnt_n     = 3'd7;
            state_n   = WR;
          end
        end
        RD: begin
          if (tx_req) begin
            shift_n   = tx_data;
            sda_out_n = tx_data[7];
            sda_oe_n  = 1'b1;
            cnt_n     = 3'd7;
          end else if (scl_fall) begin
            if (cnt == 3'd0) begin
              sda_oe_n  = 1'b0;
              sda_out_n = 1'b1;
              full_n    = 1'b0;
              state_n   = RACK;
            end else begin
              cnt_n     = cnt - 3'd1;
              shift_n   = {shift[6:0], 1'b0};
              sda_out_n = shift[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (sda_s) state_n = IGNORE;
            else       full_n  = 1'b1;
          end else if (scl_fall && full) begin
            full_n   = 1'b0;
            tx_req_n = 1'b1;
            state_n  = RD;
          end
        end
        default: begin
          sda_oe_n  = 1'b0;
          sda_out_n = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed I2C initiator bench for i2c_target_rx with a transaction-level expectation model.
module tb_i2c_target_rx;

  localparam int Q = 5;
  localparam logic [7:0] TX_TAB [4] = '{8'h96, 8'h0F, 8'h96, 8'h00};

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       scl_in, sda_in;
  logic       sda_out, sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_rx [$];
  int         tx_idx = 0;
  bit         tx_pend = 0;
  int         tx_req_cnt = 0;
  bit         quiet = 0;
  logic       ack_v, s_v;
  logic [7:0] b_v;

  always #5 clk = ~clk;

  // Open-drain bus: either side pulling low wins.
  assign scl_in  = scl_m;
  assign sda_in  = sda_m & ~(sda_oe & ~sda_out);
  assign tx_data = (tx_idx < 4) ? TX_TAB[tx_idx] : 8'h00;

  i2c_target_rx #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .sda_out(sda_out), .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic addr_acked(input logic [7:0] a);
    return a[7:1] == 7'h50;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      tx_pend = 0;
    end else begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("rx_valid unexpected", {31'd0, rx_valid}, 32'd0);
        else                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      end
      if (tx_req) begin
        tx_req_cnt++;
        tx_pend = 1;
      end else if (tx_pend) begin
        tx_pend = 0;
        if (tx_idx < 3) tx_idx++;
      end
      if (quiet) check("sda_oe while not addressed", {31'd0, sda_oe}, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic clk_bit(input logic b, output logic seen);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    seen = sda_in;
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(ack_bit, s);
  endtask

  task automatic wr_xfer(input logic [7:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                         input int n, input string tag);
    logic hit, ack;
    logic [7:0] d;
    hit = addr_acked(addr) && !addr[0];
    quiet = !hit;
    bus_start;
    write_byte(addr, ack);
    check({tag, " addr ack"}, {31'd0, ack}, {31'd0, !hit});
    check({tag, " busy"}, {31'd0, busy}, {31'd0, hit});
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : d1;
      if (hit) exp_rx.push_back(d);
      write_byte(d, ack);
      check({tag, " data ack"}, {31'd0, ack}, {31'd0, !hit});
    end
    bus_stop;
    quiet = 0;
    check({tag, " busy after stop"}, {31'd0, busy}, 32'd0);
    check({tag, " rx outstanding"}, exp_rx.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " sda_out"},  {31'd0, sda_out},  32'd1);
    check({tag, " sda_oe"},   {31'd0, sda_oe},   32'd0);
    check({tag, " rx_data"},  {24'd0, rx_data},  32'd0);
    check({tag, " rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, " tx_req"},   {31'd0, tx_req},   32'd0);
    check({tag, " busy"},     {31'd0, busy},     32'd0);
  endtask

  initial begin
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(4);
    check_reset_vals("reset");
    rst = 1'b1;
    tick(4);

    wr_xfer(8'hA0, 8'hA5, 8'h00, 1, "wr1");
    check("wr1 rx_data held", {24'd0, rx_data}, 32'hA5);

    wr_xfer(8'hA0, 8'h3C, 8'hFF, 2, "wr2");
    check("wr2 rx_data held", {24'd0, rx_data}, 32'hFF);

    bus_start;
    write_byte(8'hA1, ack_v);
    check("rd addr ack", {31'd0, ack_v}, 32'd0);
    check("rd busy", {31'd0, busy}, 32'd1);
    read_byte(1'b0, b_v);
    check("rd byte0", {24'd0, b_v}, 32'h96);
    read_byte(1'b1, b_v);
    check("rd byte1", {24'd0, b_v}, 32'h0F);
    check("rd sda_oe after nack", {31'd0, sda_oe}, 32'd0);
    bus_stop;
    check("rd busy after stop", {31'd0, busy}, 32'd0);
    check("rd tx_req pulses", tx_req_cnt, 32'd2);

    wr_xfer(8'hA2, 8'h77, 8'h00, 1, "miss");

    bus_start;
    write_byte(8'hA0, ack_v);
    check("rs first addr ack", {31'd0, ack_v}, 32'd0);
    clk_bit(1'b1, s_v); clk_bit(1'b0, s_v); clk_bit(1'b1, s_v); clk_bit(1'b0, s_v);
    wr_xfer(8'hA0, 8'h12, 8'h00, 1, "rs");
    check("rs rx_data held", {24'd0, rx_data}, 32'h12);

    bus_start;
    write_byte(8'hA1, ack_v);
    check("rst-test addr ack", {31'd0, ack_v}, 32'd0);
    clk_bit(1'b1, s_v); clk_bit(1'b1, s_v);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    check("rd bit5 sda_oe", {31'd0, sda_oe}, 32'd1);
    check("rd bit5 sda_out", {31'd0, sda_out}, 32'd0);
    rst = 1'b0;
    tick(1);
    check_reset_vals("mid-read reset");
    tick(2);
    rst = 1'b1;
    tick(4);
    wr_xfer(8'hA0, 8'h5A, 8'h00, 1, "post-reset");
    check("post-reset rx_data", {24'd0, rx_data}, 32'h5A);
    check("total tx_req pulses", tx_req_cnt, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
